// File: rtl/r_type_encoder_if.sv
// r_type_encoder_if: request and encoded-word handshakes
// plus drop statistics for the R-type encoder.
interface r_type_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [4:0]    in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [6:0]    out_control;
  logic          illegal_pulse;
  logic [7:0]    illegal_count;
  logic [LW-1:0] level;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_control,
    input  illegal_pulse, illegal_count, level
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_control,
    output illegal_pulse, illegal_count, level
  );
endinterface

// File: rtl/r_type_encoder.sv
// r_type_encoder: ALU op requests to RV32I R-type words,
// encoded at enqueue and buffered in a small FIFO.
module r_type_encoder #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  r_type_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [6:0]  control;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          in_ready_q;
  logic          pulse_q;
  logic [7:0]    count_q;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic          empty;
  logic [6:0]    funct7;
  logic [2:0]    funct3;

  always_comb begin
    funct7 = 7'h00;
    funct3 = 3'd0;
    legal  = 1'b1;
    unique case (1'b1)
      (bus.in_op == 4'd0): funct3 = 3'd0;
      (bus.in_op == 4'd1): begin
        funct7 = 7'h20;
        funct3 = 3'd0;
      end
      (bus.in_op == 4'd2): funct3 = 3'd4;
      (bus.in_op == 4'd3): funct3 = 3'd6;
      (bus.in_op == 4'd4): funct3 = 3'd7;
      (bus.in_op == 4'd5): funct3 = 3'd1;
      (bus.in_op == 4'd6): funct3 = 3'd5;
      (bus.in_op == 4'd7): begin
        funct7 = 7'h20;
        funct3 = 3'd5;
      end
      (bus.in_op == 4'd8): funct3 = 3'd2;
      (bus.in_op == 4'd9): funct3 = 3'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    wr_entry.control = {3'b000, bus.in_op};
    wr_entry.instr   = {funct7, bus.in_rs2, bus.in_rs1,
                        funct3, bus.in_rd, 7'b0110011};
  end

  assign empty   = (level_q == '0);
  assign accept  = bus.in_valid && in_ready_q;
  assign push    = accept && legal;
  assign pop     = !empty && bus.out_ready;
  assign level_d = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      pulse_q    <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q    <= level_d;
      // ready tracks next occupancy so it is a pure flop output
      in_ready_q <= (level_d != LW'(DEPTH));
      pulse_q    <= accept && !legal;
      if (accept && !legal && count_q != 8'hFF)
        count_q <= count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = !empty;
  assign bus.out_instr     = empty ? 32'd0 : mem[rd_ptr].instr;
  assign bus.out_control   = empty ? 7'd0 : mem[rd_ptr].control;
  assign bus.illegal_pulse = pulse_q;
  assign bus.illegal_count = count_q;
  assign bus.level         = level_q;
endmodule

// File: tb/tb_r_type_encoder.sv
// tb_r_type_encoder: randomized stimulus against a queue
// model of the encoder FIFO plus directed vectors.
module tb_r_type_encoder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  r_type_encoder_if #(.DEPTH(DEPTH)) bus ();

  r_type_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] F3_TAB [10] = '{
    3'd0, 3'd0, 3'd4, 3'd6, 3'd7,
    3'd1, 3'd5, 3'd5, 3'd2, 3'd3
  };

  task automatic chk(input string tag,
                     input logic [38:0] got,
                     input logic [38:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  function automatic logic [38:0] model_word(
    input logic [3:0] op, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [4:0] rd);
    logic [6:0] f7;
    f7 = (op == 4'd1 || op == 4'd7) ? 7'h20 : 7'h00;
    return {3'b000, op, f7, rs2, rs1, F3_TAB[op], rd, 7'h33};
  endfunction

  logic [38:0] q[$];
  bit          rst_prev = 1'b1;
  bit          exp_pulse = 1'b0;
  int          exp_cnt = 0;

  always @(negedge clk) begin
    bit          exp_rdy;
    bit          acc;
    bit          bad;
    logic [38:0] head;
    exp_rdy = !rst_prev && (q.size() != DEPTH);
    head = (q.size() != 0) ? q[0] : 39'd0;
    chk("in_ready", 39'(bus.in_ready), 39'(exp_rdy));
    chk("out_valid", 39'(bus.out_valid), 39'(q.size() != 0));
    chk("word", {bus.out_control, bus.out_instr}, head);
    chk("level", 39'(bus.level), 39'(q.size()));
    chk("pulse", 39'(bus.illegal_pulse), 39'(exp_pulse));
    chk("count", 39'(bus.illegal_count), 39'(exp_cnt));
    acc = bus.in_valid && exp_rdy;
    bad = bus.in_op > 4'd9;
    if (reset) begin
      q.delete();
      exp_cnt = 0;
      exp_pulse = 1'b0;
    end else begin
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (acc && !bad)
        q.push_back(model_word(bus.in_op, bus.in_rs1,
                               bus.in_rs2, bus.in_rd));
      exp_pulse = acc && bad;
      if (acc && bad && exp_cnt < 255) exp_cnt++;
    end
    rst_prev = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_ready", 39'(bus.in_ready), 39'd0);
    chk("rst_valid", 39'(bus.out_valid), 39'd0);
    step();
    reset = 1'b0;
    step();

    // single add
    req(4'd0, 5'd1, 5'd2, 5'd3);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add", 39'(bus.out_instr), 39'h002081B3);
    chk("add_ctl", 39'(bus.out_control), 39'd0);
    step();

    // back-to-back sub, sra, sltu
    req(4'd1, 5'd6, 5'd7, 5'd5);
    step();
    req(4'd7, 5'd11, 5'd12, 5'd10);
    @(negedge clk);
    chk("sub", 39'(bus.out_instr), 39'h407302B3);
    step();
    req(4'd9, 5'd0, 5'd31, 5'd1);
    @(negedge clk);
    chk("sra", 39'(bus.out_instr), 39'h40C5D533);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sltu", 39'(bus.out_instr), 39'h01F030B3);
    step();

    // fill to full with consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(4'(i), 5'(i + 1), 5'(i + 9), 5'(i + 20));
      step();
    end
    @(negedge clk);
    chk("full_ready", 39'(bus.in_ready), 39'd0);
    chk("full_level", 39'(bus.level), 39'd4);
    step();
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("pop_level", 39'(bus.level), 39'd3);
    step();
    bus.in_valid = 1'b0;
    repeat (6) step();

    // illegal then legal
    req(4'd12, 5'd1, 5'd1, 5'd1);
    step();
    req(4'd0, 5'd4, 5'd5, 5'd6);
    @(negedge clk);
    chk("ill_pulse", 39'(bus.illegal_pulse), 39'd1);
    chk("ill_cnt1", 39'(bus.illegal_count), 39'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ill_pulse_off", 39'(bus.illegal_pulse), 39'd0);
    chk("after_ill", 39'(bus.out_instr), 39'h00520333);
    step();
    for (int i = 0; i < 300; i++) begin
      req(4'($urandom_range(15, 10)), 5'd0, 5'd0, 5'd0);
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ill_sat", 39'(bus.illegal_count), 39'd255);
    step();

    // random stream
    for (int i = 0; i < 2000; i++) begin
      bus.in_valid  = 1'($urandom_range(1, 0));
      bus.in_op     = ($urandom_range(7, 0) == 0) ?
                      4'($urandom_range(15, 10)) :
                      4'($urandom_range(9, 0));
      bus.in_rs1    = 5'($urandom);
      bus.in_rs2    = 5'($urandom);
      bus.in_rd     = 5'($urandom);
      bus.out_ready = 1'($urandom_range(1, 0));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) step();

    // reset with entries queued and an illegal in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(4'(i + 2), 5'(i), 5'(i + 3), 5'(i + 6));
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst", 39'(bus.level), 39'd3);
    step();
    reset = 1'b1;
    req(4'd13, 5'd0, 5'd0, 5'd0);
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid2", 39'(bus.out_valid), 39'd0);
    chk("rst_level2", 39'(bus.level), 39'd0);
    chk("rst_pulse2", 39'(bus.illegal_pulse), 39'd0);
    repeat (5) step();
    req(4'd4, 5'd8, 5'd9, 5'd10);
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/r_type_encoder.md
# r_type_encoder

Buffered encoder that turns ALU operation requests (4-bit ALU control code plus register indices) into 32-bit RV32I R-type instruction words. It is the producer side of the instruction-to-ALU-control path: its output words decode back to the same control code. It sits between a test/sequencer front end and the instruction fetch path, with a valid/ready handshake on both sides and a small FIFO. Illegal op codes are dropped and counted.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  4  ALU control code (0..9 legal)
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer takes word when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_control  out  7  in_op zero-extended, carried with the word
- illegal_pulse  out  1  one-cycle pulse per dropped illegal request
- illegal_count  out  8  saturating count of dropped requests
- level  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Fixed word layout: [31:25]=funct7, [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=7'b0110011.
- Op to {funct7, funct3}:
  - 0 add {00,0}; 1 sub {20,0}; 2 xor {00,4}; 3 or {00,6}; 4 and {00,7}
  - 5 sll {00,1}; 6 srl {00,5}; 7 sra {20,5}; 8 slt {00,2}; 9 sltu {00,3}
  - funct7 values are hex.
- Encoding is done at enqueue. The FIFO stores {out_control, out_instr}.
- Legal accepted request: written at the write pointer; level increments.
- Illegal request (in_op 10..15):
  - Still accepted under the normal handshake.
  - Not enqueued.
  - illegal_pulse is high for exactly one cycle, the cycle after acceptance.
  - illegal_count increments, saturating at 255.
- x0 is legal in any field. No register hazard checks.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full means level==DEPTH; empty means level==0.
- Simultaneous legal push and pop: level unchanged, both pointers advance.
- Simultaneous illegal accept and pop: level decrements.

## Timing
- Reset values:
  - in_ready=0 while reset is high, 1 the cycle after.
  - out_valid=0, out_instr=0, out_control=0, illegal_pulse=0, illegal_count=0, level=0.
- in_ready = !full, registered from state. It has no combinational path from out_ready. When full, an in-cycle pop does not allow a same-cycle push.
- Latency: a request accepted at edge N makes out_valid high after edge N. There is no same-cycle bypass, so the empty-to-valid latency is 1 cycle.
- out_valid = !empty. While out_valid && !out_ready, out_instr and out_control are held stable.
- out_instr and out_control read 0 whenever out_valid=0.
- Throughput: one request per cycle in and one word per cycle out, sustained when the consumer is always ready.
- Reset mid-operation flushes all entries. Pointers, level and counter are cleared at that edge. The in-flight illegal_pulse is suppressed.
- Words leave in acceptance order, except dropped illegal requests.

## Test plan
- After reset, op 0 with rs1=1, rs2=2, rd=3 and out_ready=1. Required: out_valid high one cycle later with out_instr=0x002081B3 and out_control=0.
- Ops 1, 7 and 9 sent back-to-back:
  - op 1, rs1=6, rs2=7, rd=5: 0x407302B3
  - op 7, rs1=11, rs2=12, rd=10: 0x40C5D533
  - op 9, rs1=0, rs2=31, rd=1: 0x01F030B3
  - Required: these three words in order on consecutive cycles.
- Hold out_ready=0 and push 5 legal requests. Required: in_ready drops after the 4th, level=4, and out_instr is stable. Then assert out_ready and push in the same cycle. Required: no push accepted while full; order is preserved across pointer wrap.
- Send op 12, then op 0. Required: illegal_pulse for one cycle, illegal_count=1, only the op-0 word emitted. Then 300 illegal ops. Required: illegal_count=255.
- Stream with random out_ready at the same time as random in_valid. Required: a scoreboard matches every word, and level never exceeds 4 or goes below 0.
- Assert reset with 3 entries queued. Required: out_valid=0 and level=0 the next cycle, and no stale word is emitted after reset.
